uart_rx_engine: RTL and testbench
=================================

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-002 Parameter CLKS_PER_BIT, default 434, meaning clk cycles per bit period; legal minimum 8.
REQ-003 Parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, meaning 1 = odd parity and 0 = even parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  DATA_BITS  last received data word, LSB = first bit received.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data holds a new, correctly framed word.
REQ-010 parity_err  output  1  one-cycle pulse in the rx_valid cycle when parity mismatched.
REQ-011 framing_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_s); all FSM decisions use rx_s only.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; the bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide.
REQ-015 IDLE: rx_s=0 -> START, counter cleared; otherwise remain in IDLE.
REQ-016 START: at counter=CLKS_PER_BIT/2-1, rx_s=1 -> IDLE (false start, no outputs pulsed); rx_s=0 -> DATA, counter cleared, bit index cleared.
REQ-017 DATA: at counter=CLKS_PER_BIT-1, sample rx_s into the shift register (LSB first) and increment the bit index.
REQ-018 DATA exit: after the sample with index DATA_BITS-1 -> PARITY if PARITY_EN=1, else -> STOP.
REQ-019 PARITY: at counter=CLKS_PER_BIT-1, capture rx_s as the parity bit -> STOP.
REQ-020 Parity check: mismatch SHALL be true when XOR(data bits, parity bit) differs from PARITY_ODD.
REQ-021 STOP, rx_s=1 sampled at counter=CLKS_PER_BIT-1: rx_data <= shift register; rx_valid=1 for one cycle; parity_err=mismatch (0 when PARITY_EN=0); -> IDLE.
REQ-022 STOP, rx_s=0 sampled at counter=CLKS_PER_BIT-1: framing_err=1 for one cycle; rx_data unchanged; rx_valid and parity_err stay 0; -> WAIT_HIGH.
REQ-023 WAIT_HIGH: remain while rx_s=0 (break condition); on rx_s=1 -> IDLE.
REQ-024 Pulse timing: all outputs SHALL be registered; each pulse is asserted on the clk edge following the stop-bit sample cycle.
REQ-025 Back-to-back: a start bit immediately after a good stop bit SHALL be accepted, with no idle cycles required beyond the stop-bit sample point.
REQ-026 Sampling points: data, parity and stop sampling SHALL land at mid-bit, 1.5, 2.5, ... bit periods after the detected falling edge.
REQ-027 rx_data SHALL hold its value until the next valid frame.

Reset
REQ-028 Reset SHALL force state=IDLE; counter, bit index, shift register and synchronizer flops to their idle values (counters 0, synchronizer flops 1); rx_data=0; rx_valid=0; parity_err=0; framing_err=0; busy=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no pulses generated.
REQ-030 After reset release, a frame whose start edge precedes release SHALL NOT produce rx_valid.

Verification (CLKS_PER_BIT=16 in bench)
REQ-031 8N1 frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> exactly one rx_valid pulse, rx_data=0xA5, parity_err=0, framing_err=0.
REQ-032 rx low for 4 cycles, then high -> no pulses, busy returns to 0, FSM back in IDLE.
REQ-033 0x3C with stop bit low, line held low 40 cycles, then high -> one framing_err pulse; rx_data keeps its prior value; FSM stays in WAIT_HIGH until rx high, then IDLE.
REQ-034 PARITY_EN=1, PARITY_ODD=0, data 0x5A with parity bit 1 -> rx_valid=1 and parity_err=1 in the same cycle, rx_data=0x5A; same frame with parity bit 0 -> parity_err=0.
REQ-035 Frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, values 0x00 then 0xFF.
REQ-036 Reset pulsed during bit 3 of a frame, line then idle -> no pulses, all outputs 0; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receiver: 2-flop synchronized rx, mid-bit sampling, optional parity, framing detection.
module uart_rx_engine #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD_L     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 framing_err_q, framing_err_d;
    logic                 busy_q, busy_d;
    logic                 sync1_q, rx_s_q;
    logic [1:0]           settle_q;
    logic                 armed_q;
    logic                 mismatch;

    // Start detection is armed only once the synchronized line has been seen
    // high after reset, so a frame already in flight at release is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && rx_s_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shreg_q       <= shreg_d;
            par_q         <= par_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign mismatch = (PARITY_EN != 0) && (((^shreg_q) ^ par_q) != ODD_L);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        idx_d         = idx_q;
        shreg_d       = shreg_q;
        par_d         = par_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        parity_err_d  = 1'b0;
        framing_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_data_d    = shreg_q;
                        rx_valid_d   = 1'b1;
                        parity_err_d = mismatch;
                        state_d      = S_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - scoreboard bench for uart_rx_engine: 8N1 instance (0) and 8E1 instance (1).
module tb_uart_rx_engine;

    localparam int CPB = 16;

    typedef struct {
        bit         framing;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       parity_err_a, parity_err_b;
    logic       framing_err_a, framing_err_b;
    logic       busy_a, busy_b;

    exp_t       exp_q[2][$];
    logic [7:0] last_good[2];
    int         checks = 0;
    int         errors = 0;
    bit         done = 1'b0;

    uart_rx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
        .clk(clk), .reset(reset), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .parity_err(parity_err_a), .framing_err(framing_err_a), .busy(busy_a)
    );

    uart_rx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .reset(reset), .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .parity_err(parity_err_b), .framing_err(framing_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void mon(input int w, input logic v, input logic fe, input logic pe, input logic [7:0] d);
        exp_t e;
        if (v || fe || pe) begin
            if (exp_q[w].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse inst%0d: got valid=%0b ferr=%0b perr=%0b expected no pulse", w, v, fe, pe);
            end else begin
                e = exp_q[w].pop_front();
                chk($sformatf("valid_inst%0d", w), 32'(v), 32'(!e.framing));
                chk($sformatf("ferr_inst%0d", w), 32'(fe), 32'(e.framing));
                chk($sformatf("data_inst%0d", w), 32'(d), 32'(e.data));
                chk($sformatf("perr_inst%0d", w), 32'(pe), 32'(e.perr));
            end
        end
    endfunction

    task automatic drive(input int w, input logic v, input int n);
        if (w == 0) rx_a = v;
        else        rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    // Leaves the line low after a bad stop bit; caller decides when to release it.
    task automatic send(input int w, input logic [7:0] d, input bit par_bit, input bit stop_ok, input int extra_low);
        exp_t e;
        int   ones;
        ones = $countones(d);
        if (stop_ok) begin
            e.framing    = 1'b0;
            e.data       = d;
            e.perr       = (w == 1) ? (par_bit != (ones % 2 == 1)) : 1'b0;
            last_good[w] = d;
        end else begin
            e.framing = 1'b1;
            e.data    = last_good[w];
            e.perr    = 1'b0;
        end
        exp_q[w].push_back(e);
        drive(w, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(w, d[i], CPB);
        if (w == 1) drive(w, par_bit, CPB);
        if (stop_ok) drive(w, 1'b1, CPB);
        else         drive(w, 1'b0, CPB + extra_low);
    endtask

    task automatic do_reset(input logic line_a);
        @(negedge clk);
        reset = 1'b1;
        rx_a  = line_a;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!reset) begin
                        mon(0, rx_valid_a, framing_err_a, parity_err_a, rx_data_a);
                        mon(1, rx_valid_b, framing_err_b, parity_err_b, rx_data_b);
                    end
                end
            end
            begin
                repeat (3) @(negedge clk);
                chk("reset_rx_data", 32'(rx_data_a), 32'h0);
                chk("reset_valid", 32'(rx_valid_a | rx_valid_b), 32'h0);
                chk("reset_errs", 32'({parity_err_a, framing_err_a, parity_err_b, framing_err_b}), 32'h0);
                chk("reset_busy", 32'({busy_a, busy_b}), 32'h0);
                reset = 1'b0;
                repeat (4) @(negedge clk);

                send(0, 8'hA5, 1'b0, 1'b1, 0);
                drive(0, 1'b1, 2 * CPB);

                drive(0, 1'b0, 4);
                drive(0, 1'b1, CPB);
                chk("false_start_busy", 32'(busy_a), 32'h0);

                send(0, 8'h3C, 1'b0, 1'b0, 24);
                chk("wait_high_busy", 32'(busy_a), 32'h1);
                chk("ferr_hold_data", 32'(rx_data_a), 32'hA5);
                drive(0, 1'b1, 6);
                chk("after_break_busy", 32'(busy_a), 32'h0);
                drive(0, 1'b1, CPB);

                send(1, 8'h5A, 1'b1, 1'b1, 0);
                drive(1, 1'b1, CPB);
                send(1, 8'h5A, 1'b0, 1'b1, 0);
                drive(1, 1'b1, CPB);

                send(0, 8'h00, 1'b0, 1'b1, 0);
                send(0, 8'hFF, 1'b0, 1'b1, 0);
                drive(0, 1'b1, CPB);

                drive(0, 1'b0, CPB);
                drive(0, 1'b1, CPB);
                drive(0, 1'b0, CPB);
                drive(0, 1'b1, CPB);
                drive(0, 1'b0, CPB / 2);
                do_reset(1'b1);
                @(negedge clk);
                chk("midframe_rst_data", 32'({rx_data_a, rx_data_b}), 32'h0);
                chk("midframe_rst_flags", 32'({rx_valid_a, framing_err_a, parity_err_a, busy_a}), 32'h0);
                drive(0, 1'b1, 2 * CPB);
                chk("post_rst_idle", 32'(busy_a), 32'h0);
                send(0, 8'h81, 1'b0, 1'b1, 0);
                drive(0, 1'b1, CPB);
                chk("rx_data_81", 32'(rx_data_a), 32'h81);

                do_reset(1'b0);
                drive(0, 1'b0, 3 * CPB);
                drive(0, 1'b1, 2 * CPB);
                chk("low_at_release_busy", 32'(busy_a), 32'h0);

                for (int i = 0; i < 40; i++) begin
                    int         w;
                    logic [7:0] d;
                    bit         pb, ok;
                    int         gap;
                    w   = int'($urandom_range(0, 1));
                    d   = 8'($urandom);
                    pb  = 1'($urandom_range(0, 1));
                    ok  = ($urandom_range(0, 7) != 0);
                    send(w, d, pb, ok, int'($urandom_range(0, 20)));
                    if (!ok) drive(w, 1'b1, CPB);
                    gap = int'($urandom_range(0, CPB));
                    if (gap > 0) drive(w, 1'b1, gap);
                end

                repeat (3 * CPB) @(negedge clk);
                done = 1'b1;
            end
        join
        chk("queue_empty_inst0", 32'(exp_q[0].size()), 32'h0);
        chk("queue_empty_inst1", 32'(exp_q[1].size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
